seq_priority_encoder: RTL and testbench
=======================================

// Module: seq_priority_encoder
// PURPOSE
//   Parametrised, sequential successor to the 16-to-4 encoders. Accepts an
//   N-bit multi-hot vector with a valid/ready handshake and emits the index
//   of every set bit, one per output beat, in priority order, with a last
//   flag and a popcount. Serves request scanners and interrupt/flag
//   collectors that must service every asserted line, not only the winner.
// PARAMETERS
//   N          16               input vector width, legal range N >= 2
//   W          $clog2(N)        index width (derived, do not override)
//   CW         $clog2(N+1)      popcount width (derived, do not override)
//   MSB_FIRST  0                0: lowest set index first; 1: highest first
// PORTS
//   clk        in   1    single clock, all state on rising edge
//   rst_n      in   1    asynchronous active-low reset
//   in_vec     in   N    vector to encode, sampled on accept
//   in_valid   in   1    in_vec valid
//   in_ready   out  1    block idle; accept occurs when in_valid & in_ready
//   out_idx    out  W    index of the current set bit
//   out_valid  out  1    out_idx/out_last/out_none/out_cnt valid
//   out_ready  in   1    downstream takes the beat when out_valid & out_ready
//   out_last   out  1    current beat is the final beat for this vector
//   out_none   out  1    accepted vector was all-zero (single beat)
//   out_cnt    out  CW   popcount of accepted vector; constant over burst
// BEHAVIOUR
//   - States: IDLE, SCAN. Registers: state, pend[N], cnt[CW], none flag.
//   - Reset (rst_n low, async): state=IDLE, pend=0, cnt=0, none=0;
//     out_valid=0, out_idx=0, out_last=0, out_none=0, out_cnt=0;
//     in_ready=0 while rst_n low, 1 from the first edge after release.
//   - IDLE: in_ready=1, out_valid=0. On accept: pend<=in_vec,
//     cnt<=popcount(in_vec), none<=(in_vec==0), state<=SCAN.
//   - SCAN: in_ready=0, out_valid=1. Latency: first beat is valid in the
//     cycle after the accept edge.
//   - out_idx = lowest set bit of pend (MSB_FIRST=0) or highest (=1);
//     0 when pend==0. out_last = (popcount(pend) <= 1). out_none = none.
//   - Outputs are functions of registers only; no combinational path from
//     in_* or out_ready to any output.
//   - On a beat transfer: clear pend[out_idx]; if out_last, state<=IDLE.
//   - Zero vector: exactly one beat, out_none=1, out_last=1, out_idx=0,
//     out_cnt=0.
//   - Back-pressure: while out_valid & ~out_ready, all outputs hold stable.
//   - Throughput: a vector with k set bits takes max(k,1) beats plus one
//     IDLE cycle before the next accept. in_valid during SCAN is ignored
//     (not accepted, no state change).
//   - One-hot input: one beat whose out_idx equals the bit position.
//   - Async reset mid-burst: burst abandoned, no further beats, pend lost.
// TESTING
//   1 N=16, MSB_FIRST=0, in_vec=16'h8421, out_ready=1 -> beats idx 0,5,10,15;
//     last only on 15; cnt=4 on every beat; in_ready=1 in the cycle after.
//   2 Same with MSB_FIRST=1 -> beats idx 15,10,5,0; last on idx 0.
//   3 in_vec=16'h0000 -> one beat: none=1, last=1, idx=0, cnt=0.
//   4 in_vec=16'h0003, out_ready pattern 0,0,1,0,1 -> idx 0 held for two
//     stalled cycles, then idx 1 (last); in_valid held high throughout, no
//     second accept until back in IDLE.
//   5 in_vec=16'hFFFF -> 16 beats idx 0..15, cnt=16 (5'b10000); then
//     rst_n pulsed low during a second 16'hFFFF burst at beat 3 ->
//     out_valid=0 immediately, in_ready=1 one edge after release.
//   6 N=5 instance: every one-hot in_vec -> single beat, idx = bit position,
//     last=1; in_vec=5'b10001 -> beats idx 0 then 4.

Source files
------------

// File: rtl/seq_priority_encoder.sv
// Sequential priority encoder: walks every set bit of an accepted vector,
// one index per beat, with last flag, all-zero flag and popcount.
module seq_priority_encoder #(
  parameter int N         = 16,
  parameter int W         = $clog2(N),
  parameter int CW        = $clog2(N + 1),
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  in_vec,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  out_idx,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          out_none,
  output logic [CW-1:0] out_cnt
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  logic [0:0]    state;
  logic [N-1:0]  pend;
  logic [N-1:0]  sel;
  logic [CW-1:0] cnt;
  logic          none;
  logic          awake;
  logic [W-1:0]  idx;
  logic          one_left;
  logic          accept;
  logic          take;

  function automatic logic [CW-1:0] popcnt(input logic [N-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  // Later loop iterations override earlier ones, so the loop
  // direction decides which end of the vector wins.
  always_comb begin
    idx = '0;
    sel = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < N; i++) begin
        if (pend[i]) begin
          idx    = W'(i);
          sel    = '0;
          sel[i] = 1'b1;
        end
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (pend[i]) begin
          idx    = W'(i);
          sel    = '0;
          sel[i] = 1'b1;
        end
      end
    end
  end

  assign one_left  = ~|(pend & (pend - N'(1)));
  assign in_ready  = awake & (state == IDLE);
  assign out_valid = (state == SCAN);
  assign out_idx   = idx;
  assign out_last  = (state == SCAN) & one_left;
  assign out_none  = none;
  assign out_cnt   = cnt;

  assign accept = in_valid & in_ready;
  assign take   = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pend  <= '0;
      cnt   <= '0;
      none  <= 1'b0;
      awake <= 1'b0;
    end else begin
      awake <= 1'b1;
      unique case (state)
        IDLE: begin
          if (accept) begin
            pend  <= in_vec;
            cnt   <= popcnt(in_vec);
            none  <= ~|in_vec;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (take) begin
            pend <= pend & ~sel;
            if (one_left) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_priority_encoder.sv
// Directed bench for seq_priority_encoder: LSB/MSB-first 16-bit
// instances and a 5-bit instance, checked on the falling edge.
module tb_seq_priority_encoder;

  logic clk;
  logic rst_n;

  logic [15:0] a_vec;
  logic        a_vin, a_rdy, a_ovld, a_ordy, a_last, a_none;
  logic [3:0]  a_idx;
  logic [4:0]  a_cnt;

  logic [15:0] b_vec;
  logic        b_vin, b_rdy, b_ovld, b_ordy, b_last, b_none;
  logic [3:0]  b_idx;
  logic [4:0]  b_cnt;

  logic [4:0]  c_vec;
  logic        c_vin, c_rdy, c_ovld, c_ordy, c_last, c_none;
  logic [2:0]  c_idx;
  logic [2:0]  c_cnt;

  int nvec;
  int nerr;

  seq_priority_encoder #(.N(16), .MSB_FIRST(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_vec(a_vec), .in_valid(a_vin),
    .in_ready(a_rdy), .out_idx(a_idx), .out_valid(a_ovld),
    .out_ready(a_ordy), .out_last(a_last), .out_none(a_none),
    .out_cnt(a_cnt)
  );

  seq_priority_encoder #(.N(16), .MSB_FIRST(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_vec(b_vec), .in_valid(b_vin),
    .in_ready(b_rdy), .out_idx(b_idx), .out_valid(b_ovld),
    .out_ready(b_ordy), .out_last(b_last), .out_none(b_none),
    .out_cnt(b_cnt)
  );

  seq_priority_encoder #(.N(5), .MSB_FIRST(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_vec(c_vec), .in_valid(c_vin),
    .in_ready(c_rdy), .out_idx(c_idx), .out_valid(c_ovld),
    .out_ready(c_ordy), .out_last(c_last), .out_none(c_none),
    .out_cnt(c_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {in_ready, out_valid, out_idx, out_last, out_none, out_cnt}
  task automatic test_reset;
    logic [12:0] ea;
    logic [10:0] ec;
    rst_n = 1'b0;
    a_vec = '0; a_vin = 1'b0; a_ordy = 1'b0;
    b_vec = '0; b_vin = 1'b0; b_ordy = 1'b0;
    c_vec = '0; c_vin = 1'b0; c_ordy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    ea = '0;
    nvec++;
    if ({a_rdy, a_ovld, a_idx, a_last, a_none, a_cnt} !== ea) begin
      nerr++;
      $display("FAIL reset_a got %b want %b",
        {a_rdy, a_ovld, a_idx, a_last, a_none, a_cnt}, ea);
    end
    ec = '0;
    nvec++;
    if ({c_rdy, c_ovld, c_idx, c_last, c_none, c_cnt} !== ec) begin
      nerr++;
      $display("FAIL reset_c got %b want %b",
        {c_rdy, c_ovld, c_idx, c_last, c_none, c_cnt}, ec);
    end
    rst_n = 1'b1;
    #1;
    nvec++;
    if (a_rdy !== 1'b0) begin
      nerr++;
      $display("FAIL release_no_edge in_ready got %b want 0", a_rdy);
    end
    @(negedge clk);
    nvec++;
    if ({a_rdy, b_rdy, c_rdy} !== 3'b111) begin
      nerr++;
      $display("FAIL release_ready got %b want 111",
        {a_rdy, b_rdy, c_rdy});
    end
  endtask

  task automatic test_lsb_first;
    logic [3:0] exp_i [4];
    logic [12:0] e;
    exp_i[0] = 4'd0; exp_i[1] = 4'd5; exp_i[2] = 4'd10; exp_i[3] = 4'd15;
    a_vec = 16'h8421; a_vin = 1'b1; a_ordy = 1'b1;
    @(negedge clk);
    a_vin = 1'b0;
    for (int k = 0; k < 4; k++) begin
      e = {1'b0, 1'b1, exp_i[k], (k == 3), 1'b0, 5'd4};
      nvec++;
      if ({a_rdy, a_ovld, a_idx, a_last, a_none, a_cnt} !== e) begin
        nerr++;
        $display("FAIL lsb_beat%0d got %b want %b", k,
          {a_rdy, a_ovld, a_idx, a_last, a_none, a_cnt}, e);
      end
      @(negedge clk);
    end
    nvec++;
    if ({a_rdy, a_ovld} !== 2'b10) begin
      nerr++;
      $display("FAIL lsb_idle rdy/vld got %b want 10", {a_rdy, a_ovld});
    end
  endtask

  task automatic test_msb_first;
    logic [3:0] exp_i [4];
    logic [12:0] e;
    exp_i[0] = 4'd15; exp_i[1] = 4'd10; exp_i[2] = 4'd5; exp_i[3] = 4'd0;
    b_vec = 16'h8421; b_vin = 1'b1; b_ordy = 1'b1;
    @(negedge clk);
    b_vin = 1'b0;
    for (int k = 0; k < 4; k++) begin
      e = {1'b0, 1'b1, exp_i[k], (k == 3), 1'b0, 5'd4};
      nvec++;
      if ({b_rdy, b_ovld, b_idx, b_last, b_none, b_cnt} !== e) begin
        nerr++;
        $display("FAIL msb_beat%0d got %b want %b", k,
          {b_rdy, b_ovld, b_idx, b_last, b_none, b_cnt}, e);
      end
      @(negedge clk);
    end
    nvec++;
    if ({b_rdy, b_ovld} !== 2'b10) begin
      nerr++;
      $display("FAIL msb_idle rdy/vld got %b want 10", {b_rdy, b_ovld});
    end
  endtask

  task automatic test_zero;
    logic [12:0] e;
    a_vec = 16'h0000; a_vin = 1'b1; a_ordy = 1'b1;
    @(negedge clk);
    a_vin = 1'b0;
    e = {1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 5'd0};
    nvec++;
    if ({a_rdy, a_ovld, a_idx, a_last, a_none, a_cnt} !== e) begin
      nerr++;
      $display("FAIL zero_beat got %b want %b",
        {a_rdy, a_ovld, a_idx, a_last, a_none, a_cnt}, e);
    end
    @(negedge clk);
    nvec++;
    if ({a_rdy, a_ovld} !== 2'b10) begin
      nerr++;
      $display("FAIL zero_idle rdy/vld got %b want 10", {a_rdy, a_ovld});
    end
  endtask

  task automatic test_backpressure;
    logic pat [5];
    logic [3:0] ei [5];
    logic el [5];
    logic [12:0] e;
    pat[0] = 0; pat[1] = 0; pat[2] = 1; pat[3] = 0; pat[4] = 1;
    ei[0] = 4'd0; ei[1] = 4'd0; ei[2] = 4'd0; ei[3] = 4'd1; ei[4] = 4'd1;
    el[0] = 0; el[1] = 0; el[2] = 0; el[3] = 1; el[4] = 1;
    a_vec = 16'h0003; a_vin = 1'b1; a_ordy = 1'b0;
    @(negedge clk);
    a_vec = 16'h0005;
    for (int k = 0; k < 5; k++) begin
      a_ordy = pat[k];
      e = {1'b0, 1'b1, ei[k], el[k], 1'b0, 5'd2};
      nvec++;
      if ({a_rdy, a_ovld, a_idx, a_last, a_none, a_cnt} !== e) begin
        nerr++;
        $display("FAIL stall_cyc%0d got %b want %b", k,
          {a_rdy, a_ovld, a_idx, a_last, a_none, a_cnt}, e);
      end
      @(negedge clk);
    end
    nvec++;
    if ({a_rdy, a_ovld} !== 2'b10) begin
      nerr++;
      $display("FAIL stall_idle rdy/vld got %b want 10", {a_rdy, a_ovld});
    end
    a_ordy = 1'b1;
    @(negedge clk);
    a_vin = 1'b0;
    e = {1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 5'd2};
    nvec++;
    if ({a_rdy, a_ovld, a_idx, a_last, a_none, a_cnt} !== e) begin
      nerr++;
      $display("FAIL b2b_beat0 got %b want %b",
        {a_rdy, a_ovld, a_idx, a_last, a_none, a_cnt}, e);
    end
    @(negedge clk);
    e = {1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 5'd2};
    nvec++;
    if ({a_rdy, a_ovld, a_idx, a_last, a_none, a_cnt} !== e) begin
      nerr++;
      $display("FAIL b2b_beat1 got %b want %b",
        {a_rdy, a_ovld, a_idx, a_last, a_none, a_cnt}, e);
    end
    @(negedge clk);
  endtask

  task automatic test_full_and_reset;
    logic [12:0] e;
    a_vec = 16'hFFFF; a_vin = 1'b1; a_ordy = 1'b1;
    @(negedge clk);
    a_vin = 1'b0;
    for (int k = 0; k < 16; k++) begin
      e = {1'b0, 1'b1, 4'(k), (k == 15), 1'b0, 5'b10000};
      nvec++;
      if ({a_rdy, a_ovld, a_idx, a_last, a_none, a_cnt} !== e) begin
        nerr++;
        $display("FAIL full_beat%0d got %b want %b", k,
          {a_rdy, a_ovld, a_idx, a_last, a_none, a_cnt}, e);
      end
      @(negedge clk);
    end
    a_vin = 1'b1;
    @(negedge clk);
    a_vin = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    nvec++;
    if ({a_ovld, a_idx} !== {1'b1, 4'd3}) begin
      nerr++;
      $display("FAIL abort_pre got %b want %b", {a_ovld, a_idx},
        {1'b1, 4'd3});
    end
    rst_n = 1'b0;
    #1;
    nvec++;
    if ({a_rdy, a_ovld, a_last} !== 3'b000) begin
      nerr++;
      $display("FAIL abort_now rdy/vld/last got %b want 000",
        {a_rdy, a_ovld, a_last});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    e = {1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 5'd0};
    nvec++;
    if ({a_rdy, a_ovld, a_idx, a_last, a_none, a_cnt} !== e) begin
      nerr++;
      $display("FAIL abort_after got %b want %b",
        {a_rdy, a_ovld, a_idx, a_last, a_none, a_cnt}, e);
    end
  endtask

  task automatic test_narrow;
    logic [10:0] e;
    c_ordy = 1'b1;
    for (int b = 0; b < 5; b++) begin
      c_vec = 5'd1 << b; c_vin = 1'b1;
      @(negedge clk);
      c_vin = 1'b0;
      e = {1'b0, 1'b1, 3'(b), 1'b1, 1'b0, 3'd1};
      nvec++;
      if ({c_rdy, c_ovld, c_idx, c_last, c_none, c_cnt} !== e) begin
        nerr++;
        $display("FAIL onehot_bit%0d got %b want %b", b,
          {c_rdy, c_ovld, c_idx, c_last, c_none, c_cnt}, e);
      end
      @(negedge clk);
    end
    c_vec = 5'b10001; c_vin = 1'b1;
    @(negedge clk);
    c_vin = 1'b0;
    e = {1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 3'd2};
    nvec++;
    if ({c_rdy, c_ovld, c_idx, c_last, c_none, c_cnt} !== e) begin
      nerr++;
      $display("FAIL n5_beat0 got %b want %b",
        {c_rdy, c_ovld, c_idx, c_last, c_none, c_cnt}, e);
    end
    @(negedge clk);
    e = {1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 3'd2};
    nvec++;
    if ({c_rdy, c_ovld, c_idx, c_last, c_none, c_cnt} !== e) begin
      nerr++;
      $display("FAIL n5_beat1 got %b want %b",
        {c_rdy, c_ovld, c_idx, c_last, c_none, c_cnt}, e);
    end
    @(negedge clk);
    nvec++;
    if ({c_rdy, c_ovld} !== 2'b10) begin
      nerr++;
      $display("FAIL n5_idle rdy/vld got %b want 10", {c_rdy, c_ovld});
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_zero();
    test_backpressure();
    test_full_and_reset();
    test_narrow();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
